// File: rtl/axil_cfg_bridge.sv
// AXI4-Lite slave to single-outstanding internal config bus bridge.
// Optional cfg_ack watchdog is enabled by defining AXIL_CFG_TIMEOUT_EN.
module axil_cfg_bridge #(
  parameter int unsigned AXI_AWIDTH     = 12,
  parameter int unsigned AXI_DWIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_AWIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  input  logic [2:0]                AWPROT,
  output logic                      AWREADY,
  input  logic [AXI_DWIDTH-1:0]     WDATA,
  input  logic                      WVALID,
  input  logic [AXI_DWIDTH/8-1:0]   WSTRB,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [AXI_AWIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  input  logic [2:0]                ARPROT,
  output logic                      ARREADY,
  output logic [AXI_DWIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      cfg_req,
  output logic                      cfg_wr,
  output logic [AXI_AWIDTH-3:0]     cfg_addr,
  output logic [AXI_DWIDTH-1:0]     cfg_wdata,
  output logic [AXI_DWIDTH/8-1:0]   cfg_wstrb,
  input  logic                      cfg_ack,
  input  logic [AXI_DWIDTH-1:0]     cfg_rdata,
  input  logic                      cfg_err
);

  localparam int unsigned SW = AXI_DWIDTH / 8;
  localparam int unsigned CW = AXI_AWIDTH - 2;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {StIdle, StCfgWr, StWrResp, StCfgRd, StRdResp} state_e;

  state_e          state_q, state_d;
  logic            active_q;
  logic            aw_cap_q, aw_cap_d;
  logic            w_cap_q, w_cap_d;
  logic            grant_wr_q, grant_wr_d;
  logic [CW-1:0]   addr_q, addr_d;
  logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      resp_q, resp_d;
  logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;

  logic idle, rd_grant, aw_hs, w_hs, in_cfg_wr, in_cfg_rd, timeout;
  logic unused_inputs;

  assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  // active_q keeps every READY low while reset is asserted and for the release edge.
  assign idle      = active_q && (state_q == StIdle);
  assign in_cfg_wr = (state_q == StCfgWr);
  assign in_cfg_rd = (state_q == StCfgRd);
  // A partially captured write commits the bridge; otherwise round-robin on last_grant.
  assign rd_grant  = idle && !aw_cap_q && !w_cap_q && ARVALID &&
                     !((AWVALID || WVALID) && !grant_wr_q);
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;

`ifdef AXIL_CFG_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (!cfg_req) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = cfg_req && (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      active_q   <= 1'b0;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      grant_wr_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      resp_q     <= RespOkay;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= 1'b1;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      grant_wr_q <= grant_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    grant_wr_d = grant_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          aw_cap_d = 1'b1;
          addr_d   = AWADDR[AXI_AWIDTH-1:2];
        end
        if (w_hs) begin
          w_cap_d = 1'b1;
          wdata_d = WDATA;
          wstrb_d = WSTRB;
        end
        if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
          state_d = StCfgWr;
        end else if (rd_grant) begin
          addr_d  = ARADDR[AXI_AWIDTH-1:2];
          wdata_d = '0;
          wstrb_d = '0;
          state_d = StCfgRd;
        end
      end
      StCfgWr: begin
        if (cfg_ack) begin
          resp_d  = cfg_err ? RespSlvErr : RespOkay;
          state_d = StWrResp;
        end else if (timeout) begin
          resp_d  = RespSlvErr;
          state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (BREADY) begin
          aw_cap_d   = 1'b0;
          w_cap_d    = 1'b0;
          grant_wr_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StCfgRd: begin
        if (cfg_ack) begin
          resp_d  = cfg_err ? RespSlvErr : RespOkay;
          rdata_d = cfg_rdata;
          state_d = StRdResp;
        end else if (timeout) begin
          resp_d  = RespSlvErr;
          rdata_d = '0;
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        if (RREADY) begin
          grant_wr_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    AWREADY   = idle && !aw_cap_q && !rd_grant;
    WREADY    = idle && !w_cap_q && !rd_grant;
    ARREADY   = rd_grant;
    cfg_req   = in_cfg_wr || in_cfg_rd;
    cfg_wr    = in_cfg_wr;
    cfg_addr  = cfg_req ? addr_q : '0;
    cfg_wdata = in_cfg_wr ? wdata_q : '0;
    cfg_wstrb = in_cfg_wr ? wstrb_q : '0;
    BVALID    = (state_q == StWrResp);
    BRESP     = BVALID ? resp_q : RespOkay;
    RVALID    = (state_q == StRdResp);
    RRESP     = RVALID ? resp_q : RespOkay;
    RDATA     = RVALID ? rdata_q : '0;
  end

endmodule
